uart_tx_frame: RTL

- Serial frame transmitter: the sending end of the team's UART-style serial link, and the counterpart of the serial receiver/deserializer built from positive-edge D flip-flops.
- Accepts a parallel word over a valid/ready handshake.
- Shifts the word out LSB-first on a single registered line, framed by a start bit, an optional even-parity bit and stop bit(s).
- Sits between a parallel producer (counter, register file, test pattern source) and the serial pin.

---
 rtl/uart_tx_frame_pkg.sv | 15 +
 rtl/uart_tx_frame_bit_timer.sv | 27 ++
 rtl/uart_tx_frame.sv | 121 ++++++++++++
 3 files changed

// File: rtl/uart_tx_frame_pkg.sv
// rtl/uart_tx_frame_pkg.sv - shared state encoding and line levels for the serial frame transmitter
package uart_tx_frame_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_LVL = 1'b0;

endpackage

// File: rtl/uart_tx_frame_bit_timer.sv
// rtl/uart_tx_frame_bit_timer.sv - pulses bit_done once every CLKS_PER_BIT cycles while run is high
module uart_tx_frame_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic res,
  input  logic run,
  output logic bit_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // With CLKS_PER_BIT=1 the counter sits at zero and every running cycle is a boundary.
  assign bit_done = run && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (res || !run || bit_done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - LSB-first serial frame transmitter with start, optional even parity and stop bits
module uart_tx_frame
  import uart_tx_frame_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              res,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid,
  output logic              ready,
  output logic              tx,
  output logic              busy
);

  localparam logic [4:0] LAST_DATA = 5'(DATA_W - 1);
  localparam logic [4:0] LAST_STOP = 5'(STOP_BITS - 1);

  state_t              state, state_n;
  logic [DATA_W-1:0]   shift, shift_n;
  logic                parity, parity_n;
  logic [4:0]          bit_cnt, bit_cnt_n;
  logic                tx_n;
  logic                bit_done;

  // ready/busy decode only the state register, so valid never reaches them combinationally.
  assign ready = (state == S_IDLE);
  assign busy  = (state != S_IDLE);

  uart_tx_frame_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .res     (res),
    .run     (busy),
    .bit_done(bit_done)
  );

  always_ff @(posedge clk) begin
    if (res) begin
      state   <= S_IDLE;
      shift   <= '0;
      parity  <= 1'b0;
      bit_cnt <= '0;
      tx      <= LINE_IDLE;
    end else begin
      state   <= state_n;
      shift   <= shift_n;
      parity  <= parity_n;
      bit_cnt <= bit_cnt_n;
      tx      <= tx_n;
    end
  end

  always_comb begin
    state_n   = state;
    shift_n   = shift;
    parity_n  = parity;
    bit_cnt_n = bit_cnt;
    tx_n      = tx;
    case (state)
      S_IDLE: begin
        if (valid) begin
          shift_n   = data_in;
          parity_n  = ^data_in;
          bit_cnt_n = '0;
          state_n   = S_START;
          tx_n      = START_LVL;
        end
      end
      S_START: begin
        if (bit_done) begin
          state_n = S_DATA;
          tx_n    = shift[0];
        end
      end
      S_DATA: begin
        if (bit_done) begin
          if (bit_cnt == LAST_DATA) begin
            bit_cnt_n = '0;
            if (PARITY_EN != 0) begin
              state_n = S_PARITY;
              tx_n    = parity;
            end else begin
              state_n = S_STOP;
              tx_n    = LINE_IDLE;
            end
          end else begin
            bit_cnt_n = bit_cnt + 5'd1;
            shift_n   = shift >> 1;
            tx_n      = shift_n[0];
          end
        end
      end
      S_PARITY: begin
        if (bit_done) begin
          state_n = S_STOP;
          tx_n    = LINE_IDLE;
        end
      end
      S_STOP: begin
        if (bit_done) begin
          if (bit_cnt == LAST_STOP) begin
            bit_cnt_n = '0;
            state_n   = S_IDLE;
          end else begin
            bit_cnt_n = bit_cnt + 5'd1;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        tx_n    = LINE_IDLE;
      end
    endcase
  end

endmodule
